// File: rtl/usb_fs_tx.sv
// Full-speed USB line transmitter.
// Accepts packet bytes on a valid/ready stream and drives the D+/D- pair:
// SYNC, LSB-first serialisation, bit stuffing, NRZI encoding and EOP.
module usb_fs_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       dp,
  output logic       dn,
  output logic       oe,
  output logic       busy,
  output logic       underrun
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]    SYNC_PAT = 8'h80;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SYNC    = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_EOP_SE0 = 3'd3;
  localparam logic [2:0] S_EOP_J   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;       // clk cycles within the current bit period
  logic [2:0]    bit_idx_q, bit_idx_d; // bit of the byte on the line, or EOP SE0 period
  logic [7:0]    shift_q, shift_d;   // shift_q[0] is the data bit on the line
  logic          last_q, last_d;     // current byte closes the packet
  logic [2:0]    ones_q, ones_d;     // consecutive 1 data bits sent so far
  logic          level_q, level_d;   // NRZI level, 1 = J
  logic          dp_q, dp_d;
  logic          dn_q, dn_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;

  logic tick;
  logic in_stream;
  logic byte_end;
  logic need_byte;

  // Emission of one bit period on the line, resolved by the next-state logic.
  logic do_emit;
  logic emit_bit;
  logic emit_stuff;

  assign tick      = (cnt_q == CNT_MAX);
  assign in_stream = (state_q == S_SYNC) || (state_q == S_DATA);
  // A byte is finished when its bit 7 period ends and no stuff bit is still owed.
  assign byte_end  = in_stream && tick && (bit_idx_q == 3'd7) && (ones_q != 3'd6);
  assign need_byte = byte_end && ((state_q == S_SYNC) || !last_q);

  // Handshake and underrun are combinational in the byte-boundary cycle.
  assign tx_ready = !reset && need_byte && tx_valid;
  assign underrun = !reset && need_byte && !tx_valid;

  assign dp   = dp_q;
  assign dn   = dn_q;
  assign oe   = oe_q;
  assign busy = busy_q;

  // Next-state logic: bit timing, shifter, stuffing and line encoding.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = (state_q == S_IDLE || tick) ? '0 : cnt_q + CW'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    last_d     = last_q;
    ones_d     = ones_q;
    level_d    = level_q;
    dp_d       = dp_q;
    dn_d       = dn_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    do_emit    = 1'b0;
    emit_bit   = 1'b0;
    emit_stuff = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d   = S_SYNC;
          shift_d   = SYNC_PAT;
          bit_idx_d = 3'd0;
          last_d    = 1'b0;
          ones_d    = 3'd0;
          oe_d      = 1'b1;
          busy_d    = 1'b1;
          do_emit   = 1'b1;
          emit_bit  = SYNC_PAT[0];
        end
      end

      S_SYNC, S_DATA: begin
        if (tick) begin
          if (ones_q == 3'd6) begin
            // Stuff a 0; the shifter holds so the pending data bit follows.
            do_emit    = 1'b1;
            emit_stuff = 1'b1;
          end else if (bit_idx_q != 3'd7) begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            do_emit   = 1'b1;
            emit_bit  = shift_q[1];
          end else if (tx_ready) begin
            state_d   = S_DATA;
            shift_d   = tx_data;
            last_d    = tx_last;
            bit_idx_d = 3'd0;
            do_emit   = 1'b1;
            emit_bit  = tx_data[0];
          end else begin
            // Either the last byte is done or the source starved us.
            state_d   = S_EOP_SE0;
            bit_idx_d = 3'd0;
            ones_d    = 3'd0;
            dp_d      = 1'b0;
            dn_d      = 1'b0;
          end
        end
      end

      S_EOP_SE0: begin
        if (tick) begin
          if (bit_idx_q == 3'd1) begin
            state_d   = S_EOP_J;
            bit_idx_d = 3'd0;
            level_d   = 1'b1;
            dp_d      = 1'b1;
            dn_d      = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      S_EOP_J: begin
        if (tick) begin
          state_d = S_IDLE;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
        level_d = 1'b1;
        dp_d    = 1'b1;
        dn_d    = 1'b0;
      end
    endcase

    // NRZI: a 0 (data or stuff) toggles the level, a 1 holds it.
    if (do_emit) begin
      level_d = emit_bit ? level_q : !level_q;
      dp_d    = level_d;
      dn_d    = !level_d;
      if (emit_stuff || !emit_bit) ones_d = 3'd0;
      else                         ones_d = ones_q + 3'd1;
    end
  end

  // State registers with synchronous reset back to an idle J line.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      last_q    <= 1'b0;
      ones_q    <= 3'd0;
      level_q   <= 1'b1;
      dp_q      <= 1'b1;
      dn_q      <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      ones_q    <= ones_d;
      level_q   <= level_d;
      dp_q      <= dp_d;
      dn_q      <= dn_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_usb_fs_tx.sv
// Scoreboard bench for usb_fs_tx: a C=4 instance checked per bit period
// against queued line symbols, and a C=1 instance whose line is decoded
// back into bytes.
`timescale 1ns/1ps
module tb_usb_fs_tx;

  localparam int         C4 = 4;
  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] LS = 2'b00;

  logic clk = 1'b0;
  logic reset;

  logic [7:0] a_data;
  logic       a_valid, a_last, a_ready, a_dp, a_dn, a_oe, a_busy, a_und;
  logic [7:0] b_data;
  logic       b_valid, b_last, b_ready, b_dp, b_dn, b_oe, b_busy, b_und;

  always #5 clk = ~clk;

  usb_fs_tx #(.CLKS_PER_BIT(C4)) dut_a (
    .clk(clk), .reset(reset), .tx_data(a_data), .tx_valid(a_valid), .tx_last(a_last),
    .tx_ready(a_ready), .dp(a_dp), .dn(a_dn), .oe(a_oe), .busy(a_busy), .underrun(a_und)
  );

  usb_fs_tx #(.CLKS_PER_BIT(1)) dut_b (
    .clk(clk), .reset(reset), .tx_data(b_data), .tx_valid(b_valid), .tx_last(b_last),
    .tx_ready(b_ready), .dp(b_dp), .dn(b_dn), .oe(b_oe), .busy(b_busy), .underrun(b_und)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input int val);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event, value %0d at %0t", name, val, $time);
  endtask

  // Expected traffic for dut_a.
  logic [1:0] sym_q[$];
  int         rdy_q[$];
  int         und_q[$];
  int         len_q[$];
  // Expected bytes for dut_b.
  logic [7:0] b_exp[$];

  bit         mon_en = 1'b0;
  int         phase  = 0;
  logic [1:0] cur_sym = LJ;

  // Reference encoder: SYNC + bytes, stuffing, NRZI, EOP; queues expectations.
  task automatic push_model(input logic [7:0] b[], input bit ends_last);
    logic       lvl = 1'b1;
    int         ones = 0;
    int         per = 0;
    logic [7:0] cur;
    for (int k = 0; k <= b.size(); k++) begin
      cur = (k == 0) ? 8'h80 : b[k-1];
      if (k > 0) rdy_q.push_back(per * C4 - 1);
      for (int j = 0; j < 8; j++) begin
        if (!cur[j]) lvl = !lvl;
        sym_q.push_back({lvl, !lvl});
        per++;
        ones = cur[j] ? ones + 1 : 0;
        if (ones == 6) begin
          lvl = !lvl;
          sym_q.push_back({lvl, !lvl});
          per++;
          ones = 0;
        end
      end
    end
    if (!ends_last) und_q.push_back(per * C4 - 1);
    sym_q.push_back(LS);
    sym_q.push_back(LS);
    sym_q.push_back(LJ);
    per += 3;
    len_q.push_back(per * C4);
  endtask

  // Monitor for dut_a: line symbol per bit period, stability inside it,
  // handshake/underrun timing and total oe-high length.
  always @(negedge clk) begin
    if (mon_en) begin
      if (a_oe === 1'b1) begin
        check("busy_while_oe", {31'd0, a_busy}, 32'd1);
        if (phase % C4 == 0) begin
          if (sym_q.size() == 0) fail_now("extra_bit_period", phase);
          else begin
            cur_sym = sym_q.pop_front();
            check("line_sym", {30'd0, a_dp, a_dn}, {30'd0, cur_sym});
          end
        end else begin
          check("line_stable", {30'd0, a_dp, a_dn}, {30'd0, cur_sym});
        end
        if (a_ready === 1'b1 && a_valid === 1'b1) begin
          if (rdy_q.size() == 0) fail_now("extra_tx_ready", phase);
          else check("tx_ready_phase", phase, rdy_q.pop_front());
        end
        if (a_und === 1'b1) begin
          if (und_q.size() == 0) fail_now("extra_underrun", phase);
          else check("underrun_phase", phase, und_q.pop_front());
        end
        phase++;
      end else begin
        if (phase != 0) begin
          if (len_q.size() == 0) fail_now("extra_packet", phase);
          else check("oe_high_cycles", phase, len_q.pop_front());
          phase = 0;
        end
        check("idle_line", {27'd0, a_dp, a_dn, a_busy, a_ready, a_und}, 32'b10000);
      end
    end
  end

  // Decoder for dut_b: NRZI decode, unstuff, compare SYNC, bytes and EOP.
  logic [1:0] b_syms[$];

  task automatic decode_b();
    int         n = b_syms.size();
    logic [1:0] prev = LJ;
    int         ones = 0;
    bit         bits[$];
    logic [7:0] acc;
    int         nexp = b_exp.size();
    if (n < 3) begin
      fail_now("b_short_packet", n);
      return;
    end
    check("b_eop_se0_a", {30'd0, b_syms[n-3]}, {30'd0, LS});
    check("b_eop_se0_b", {30'd0, b_syms[n-2]}, {30'd0, LS});
    check("b_eop_j",     {30'd0, b_syms[n-1]}, {30'd0, LJ});
    for (int i = 0; i < n - 3; i++) begin
      bit bv;
      bv   = (b_syms[i] == prev);
      prev = b_syms[i];
      if (ones == 6) begin
        check("b_stuff_bit", {31'd0, bv}, 32'd0);
        ones = 0;
      end else begin
        bits.push_back(bv);
        ones = bv ? ones + 1 : 0;
      end
    end
    check("b_bit_count", bits.size(), 8 * (nexp + 1));
    for (int k = 0; k * 8 + 7 < bits.size(); k++) begin
      acc = 8'h00;
      for (int j = 0; j < 8; j++) acc[j] = bits[k*8 + j];
      if (k == 0) check("b_sync", {24'd0, acc}, 32'h80);
      else if (b_exp.size() > 0) check("b_byte", {24'd0, acc}, {24'd0, b_exp.pop_front()});
      else fail_now("b_extra_byte", int'(acc));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (b_oe === 1'b1) b_syms.push_back({b_dp, b_dn});
      else if (b_syms.size() > 0) begin
        decode_b();
        b_syms.delete();
      end
    end
  end

  task automatic drive(input bit sel, input logic v, input logic [7:0] d, input logic l);
    if (sel) begin
      b_valid = v; b_data = d; b_last = l;
    end else begin
      a_valid = v; a_data = d; a_last = l;
    end
  endtask

  // Offer the bytes, advance on each handshake, then wait for the line to go idle.
  task automatic send_pkt(input bit sel, input logic [7:0] b[], input bit ends_last);
    int i = 0;
    int guard = 0;
    int n = b.size();
    drive(sel, 1'b1, b[0], ends_last && n == 1);
    while (i < n && guard < 4000) begin
      @(negedge clk);
      guard++;
      if ((sel ? b_ready : a_ready) === 1'b1) begin
        @(posedge clk); #1;
        i++;
        if (i < n) drive(sel, 1'b1, b[i], ends_last && i == n - 1);
        else       drive(sel, 1'b0, 8'h00, 1'b0);
      end
    end
    if (i < n) begin
      fail_now("handshake_timeout", i);
      drive(sel, 1'b0, 8'h00, 1'b0);
    end
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((sel ? b_oe : a_oe) === 1'b1 && guard < 4000);
    if (guard >= 4000) fail_now("oe_fall_timeout", guard);
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic [7:0] pk[];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b1, 8'hAA, 1'b1); // reset must win over tx_valid
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", {26'd0, a_dp, a_dn, a_oe, a_busy, a_ready, a_und}, 32'b100000);
    check("reset_b", {26'd0, b_dp, b_dn, b_oe, b_busy, b_ready, b_und}, 32'b100000);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // ACK: line KJKJKJKK JJKJJKKK SE0 SE0 J, ready at phase 31, 76 cycles.
    sym_q = '{LK, LJ, LK, LJ, LK, LJ, LK, LK,
              LJ, LJ, LK, LJ, LJ, LK, LK, LK,
              LS, LS, LJ};
    rdy_q.push_back(31);
    len_q.push_back(76);
    pk = '{8'hD2};
    send_pkt(1'b0, pk, 1'b1);

    // 0xFF: stuff after 5th data bit, 9 data periods, 80 cycles.
    sym_q = '{LK, LJ, LK, LJ, LK, LJ, LK, LK,
              LK, LK, LK, LK, LK, LJ, LJ, LJ, LJ,
              LS, LS, LJ};
    rdy_q.push_back(31);
    len_q.push_back(80);
    pk = '{8'hFF};
    send_pkt(1'b0, pk, 1'b1);

    // Back-to-back bytes with tx_valid held high.
    pk = '{8'h69, 8'h00, 8'h10};
    push_model(pk, 1'b1);
    send_pkt(1'b0, pk, 1'b1);

    // Underrun after a non-final byte.
    pk = '{8'hC3};
    push_model(pk, 1'b0);
    send_pkt(1'b0, pk, 1'b0);

    // Reset in cycle 40 of a packet: 10 bit periods seen, then idle J.
    sym_q = '{LK, LJ, LK, LJ, LK, LJ, LK, LK, LK, LJ};
    rdy_q.push_back(31);
    len_q.push_back(40);
    drive(1'b0, 1'b1, 8'h55, 1'b1);
    repeat (33) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid_packet", {27'd0, a_dp, a_dn, a_oe, a_busy, a_ready}, 32'b10000);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Fresh packet after reset must start SYNC from J.
    pk = '{8'hA5, 8'h3C};
    push_model(pk, 1'b1);
    send_pkt(1'b0, pk, 1'b1);

    // C=1 stress: 16 random bytes, recovered by the decoder.
    pk = new[16];
    foreach (pk[i]) pk[i] = 8'($urandom_range(0, 255));
    foreach (pk[i]) b_exp.push_back(pk[i]);
    send_pkt(1'b1, pk, 1'b1);

    repeat (4) @(posedge clk);
    check("sym_q_drained", sym_q.size(), 0);
    check("rdy_q_drained", rdy_q.size(), 0);
    check("und_q_drained", und_q.size(), 0);
    check("len_q_drained", len_q.size(), 0);
    check("b_exp_drained", b_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_fs_tx.md
# usb_fs_tx

Full-speed USB line transmitter. It takes packet bytes over a valid/ready byte stream and drives the D+/D− pair:
- prepends SYNC;
- serialises each byte LSB first;
- applies bit stuffing and NRZI encoding;
- ends each packet with EOP.

It sits between the packet/protocol layer and the transceiver pads, and is the transmit counterpart of the full-speed line receiver.

## Interface
Parameters:
- CLKS_PER_BIT, default 4: clk cycles per USB bit period (48 MHz clk gives 12 Mb/s). Must be ≥ 1.

Ports:
- clk  input  1  Single clock; all logic on its rising edge.
- reset  input  1  Synchronous, active-high reset.
- tx_data  input  8  Packet byte; the PID is the first byte.
- tx_valid  input  1  tx_data is valid. Holding it high in IDLE starts a packet.
- tx_last  input  1  Qualifies tx_data as the final byte of the packet.
- tx_ready  output  1  Byte accepted on this cycle when tx_valid && tx_ready.
- dp  output  1  D+ line value.
- dn  output  1  D− line value.
- oe  output  1  Line driver enable.
- busy  output  1  High from the start of SYNC to the end of EOP.
- underrun  output  1  One-cycle pulse when a byte is needed but tx_valid is low.

## Operation
- Line states: J = (dp=1, dn=0); K = (0,1); SE0 = (0,0).
- When oe=0, dp/dn hold J.
- Reset values: dp=1, dn=0, oe=0, tx_ready=0, busy=0, underrun=0. State goes to IDLE; bit counter and ones counter clear; NRZI level is J.
- FSM states: IDLE → SYNC → DATA → EOP_SE0 → EOP_J → IDLE.
- IDLE: when tx_valid=1, go to SYNC. No byte is consumed yet.
- SYNC: transmit the pattern 0x80 LSB first, i.e. bits 0000_0001. Line sequence is KJKJKJKK.
- DATA: a byte is loaded whenever the previous byte (or SYNC) finishes its last bit period.
  - tx_ready is combinational and high only in that cycle, and only if tx_valid=1.
  - tx_last is captured with the byte.
  - If tx_valid=0 when a byte is needed: pulse underrun and go directly to EOP_SE0.
  - After the final bit of a byte captured with tx_last=1, go to EOP_SE0.
- Bit stuffing: a ones counter counts consecutive 1 data bits, including the final 1 of SYNC.
  - After 6 consecutive 1s, insert one 0 bit period, clear the counter and do not advance the shifter.
  - A 0 bit clears the counter.
  - A stuff bit due after the last data bit is sent before EOP.
- NRZI: a 0 bit (including stuffed bits) toggles J/K; a 1 bit holds the level.
- EOP_SE0: drive SE0 for 2 bit periods.
- EOP_J: drive J for 1 bit period, with oe still 1. Then go to IDLE with oe=0 and busy=0.
- A new packet may start in the first IDLE cycle.
- Reset mid-packet: on the next edge, go to IDLE with oe=0 and J. No EOP is sent. Any pending byte is dropped.
- Reset has priority over tx_valid.

## Timing
- Let C = CLKS_PER_BIT. A bit tick occurs every C cycles.
- dp/dn/oe are registered and change only on bit-period boundaries.
- tx_valid=1 in IDLE at cycle N:
  - oe=1, busy=1 and the first SYNC K appear at cycle N+1.
  - Bit period k occupies cycles N+1+kC .. N+(k+1)C.
- tx_ready for byte 0 is at cycle N+8C, the last cycle of SYNC bit 7.
- Each subsequent tx_ready comes in the last cycle of the previous byte's final bit period. Stuff bits delay it by C cycles each.
- underrun pulses in the cycle tx_ready would have been high. SE0 starts at the next bit boundary.
- Total oe-high duration = (8 + 8·bytes + stuff_bits + 3)·C cycles.
- tx_ready is never high outside SYNC/DATA. At most one byte is accepted per byte-time.

## Test plan
- Single ACK, C=4: tx_data=0xD2, tx_last=1.
  - Expect line KJKJKJKK JJKJJKKK SE0 SE0 J.
  - oe high for exactly 76 cycles; one tx_ready at cycle N+32; busy falls together with oe.
- Stuffing, C=4: single byte 0xFF, tx_last=1.
  - Stuff bit is inserted after the 5th data bit (SYNC's trailing 1 counts).
  - 9 data periods; oe high 80 cycles; ones counter never exceeds 6.
- Back-to-back, C=4: bytes 0x69, 0x00, 0x10 with tx_valid held high.
  - tx_ready exactly 3 times, 32 cycles apart (no stuffing).
  - No gap between bytes on the line; EOP follows byte 3.
- Underrun, C=4: byte 0xC3 (tx_last=0), then tx_valid low.
  - underrun pulses once at the next byte boundary.
  - Line goes SE0 SE0 J, then oe=0.
- Reset mid-DATA:
  - Assert reset in cycle 40 of a packet.
  - Next edge: oe=0, dp=1, dn=0, busy=0, tx_ready=0.
  - A new packet started after reset produces correct SYNC from J.
- C=1 stress: a random 16-byte packet.
  - Decode dp/dn with a reference NRZI/unstuff model; recovered bytes must match.
  - EOP is 2 SE0 + 1 J cycles.
